// File: rtl/npu_pkg.sv
// Shared types, protocol codes and helpers for the NPU header-forwarding engine.
package npu_pkg;

   localparam logic [7:0]  ETH_PROTO_DEF     = 8'd128;
   localparam logic [7:0]  IPV4_TYPE_DEF     = 8'd64;
   localparam logic [15:0] DEFAULT_MODULE_ID = 16'h0001;

   localparam logic [3:0] PC_IN    = 4'd0;
   localparam logic [3:0] PC_OUT   = 4'd1;
   localparam logic [3:0] PC_DROP  = 4'd2;
   localparam logic [3:0] PC_STALL = 4'd3;

   typedef struct packed {
      logic [3:0]  version;
      logic [3:0]  hLength;
      logic [7:0]  tos;
      logic [15:0] length;
      logic [15:0] identification;
      logic [15:0] flagsOffset;
      logic [7:0]  ttl;
      logic [7:0]  protocol;
      logic [15:0] chksum;
      logic [31:0] srcAddr;
      logic [31:0] dstAddr;
   } ipv4_hdr_t;

   typedef struct packed {
      logic [7:0]  l2Protocol;
      logic [47:0] eth_dstAddr;
      logic [47:0] eth_srcAddr;
      logic [7:0]  eth_l3Type;
      logic [15:0] eth_length;
      ipv4_hdr_t   ipv4;
   } hdr_t;

   typedef struct packed {
      logic        request;
      logic [15:0] moduleId;
      logic [7:0]  portId;
      logic [15:0] pcValue;
      logic [3:0]  pcType;
   } pc_msg_t;

   // 16-bit ones-complement add; the folded carry cannot overflow again.
   function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] sum;
      // NOTE: blocking assignments inside functions and always_comb; state uses <= only.
      sum = {1'b0, a} + {1'b0, b};
      return sum[15:0] + {15'd0, sum[16]};
   endfunction

endpackage

// File: rtl/npu_if.sv
// Header stream (in/out) and daisy-chained performance-counter bus of the NPU top.
interface npu_if;
   import npu_pkg::*;

   logic    in_valid;
   logic    in_ready;
   hdr_t    in_bits;
   logic    out_valid;
   logic    out_ready;
   hdr_t    out_bits;
   logic    pcIn_valid;
   pc_msg_t pcIn_bits;
   logic    pcOut_valid;
   pc_msg_t pcOut_bits;

   modport master (
      output in_valid, in_bits, out_ready, pcIn_valid, pcIn_bits,
      input  in_ready, out_valid, out_bits, pcOut_valid, pcOut_bits
   );

   modport slave (
      input  in_valid, in_bits, out_ready, pcIn_valid, pcIn_bits,
      output in_ready, out_valid, out_bits, pcOut_valid, pcOut_bits
   );

endinterface

// File: rtl/npu_pc_node.sv
// Counter bank plus PC-bus node: answers reads addressed to MODULE_ID, forwards everything else.
module npu_pc_node import npu_pkg::*; #(
   parameter logic [15:0] MODULE_ID = DEFAULT_MODULE_ID
) (
   input  logic    clk,
   input  logic    reset,
   input  logic    inc_in_i,
   input  logic    inc_out_i,
   input  logic    inc_drop_i,
   input  logic    inc_stall_i,
   input  logic    pc_valid_i,
   input  pc_msg_t pc_msg_i,
   output logic    pc_valid_o,
   output pc_msg_t pc_msg_o
);

   logic [3:0]       inc;
   logic [3:0][15:0] cnt_q, cnt_d;
   logic [15:0]      sel_value;
   logic             hit;
   logic             pc_valid_q, pc_valid_d;
   pc_msg_t          pc_msg_q, pc_msg_d;

   assign inc = {inc_stall_i, inc_drop_i, inc_out_i, inc_in_i};

   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
      sel_value = '0;
      for (int i = 0; i < 4; i++) cnt_d[i] = cnt_q[i] + 16'(inc[i]);
      if (pc_msg_i.pcType[3:2] == 2'b00) sel_value = cnt_q[pc_msg_i.pcType[1:0]];

      hit        = pc_valid_i && pc_msg_i.request && (pc_msg_i.moduleId == MODULE_ID);
      pc_valid_d = pc_valid_i;
      pc_msg_d   = pc_msg_i;
      if (hit) begin
         pc_valid_d       = 1'b1;
         pc_msg_d.request = 1'b0;
         pc_msg_d.pcValue = sel_value;
      end
   end

   // NOTE: sequential state updates use non-blocking assignments so all flops sample together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q      <= '0;
         pc_valid_q <= 1'b0;
         pc_msg_q   <= '0;
      end else begin
         cnt_q      <= cnt_d;
         pc_valid_q <= pc_valid_d;
         pc_msg_q   <= pc_msg_d;
      end
   end

   assign pc_valid_o = pc_valid_q;
   assign pc_msg_o   = pc_msg_q;

endmodule

// File: rtl/npu_top.sv
// Two-stage header forwarding pipeline: S1 classifies, S2 decrements TTL and patches the checksum.
module npu_top import npu_pkg::*; #(
   parameter logic [15:0] MODULE_ID = DEFAULT_MODULE_ID,
   parameter logic [7:0]  ETH_PROTO = ETH_PROTO_DEF,
   parameter logic [7:0]  IPV4_TYPE = IPV4_TYPE_DEF
) (
   input  logic clk,
   input  logic reset,
   npu_if.slave io
);

   logic  s1_v_q, s1_v_d, s1_ipv4_q, s1_ipv4_d, s1_drop_q, s1_drop_d;
   hdr_t  s1_hdr_q, s1_hdr_d;
   logic  s2_v_q, s2_v_d;
   hdr_t  s2_hdr_q, s2_hdr_d;
   hdr_t  mod_hdr;
   logic  s1_en, s2_en, in_is_ipv4;
   logic  [7:0]  ttl_dec;
   logic  [15:0] m_old, m_new;

   // Each stage may load when it is empty or its contents move on this edge.
   assign s2_en       = !s2_v_q || io.out_ready;
   assign s1_en       = !s1_v_q || s2_en;
   assign io.in_ready = s1_en;
   assign in_is_ipv4  = (io.in_bits.l2Protocol == ETH_PROTO) &&
                        (io.in_bits.eth_l3Type == IPV4_TYPE);

   always_comb begin
      s1_v_d    = s1_v_q;
      s1_hdr_d  = s1_hdr_q;
      s1_ipv4_d = s1_ipv4_q;
      s1_drop_d = s1_drop_q;
      if (s1_en) begin
         s1_v_d    = io.in_valid;
         s1_hdr_d  = io.in_bits;
         s1_ipv4_d = in_is_ipv4;
         s1_drop_d = in_is_ipv4 && (io.in_bits.ipv4.ttl <= 8'd1);
      end
   end

   always_comb begin
      ttl_dec = s1_hdr_q.ipv4.ttl - 8'd1;
      m_old   = {s1_hdr_q.ipv4.ttl, s1_hdr_q.ipv4.protocol};
      m_new   = {ttl_dec, s1_hdr_q.ipv4.protocol};
      mod_hdr = s1_hdr_q;
      // Incremental checksum update: HC' = ~(~HC + ~m + m').
      if (s1_ipv4_q) begin
         mod_hdr.ipv4.ttl    = ttl_dec;
         mod_hdr.ipv4.chksum = ~ones_add(ones_add(~s1_hdr_q.ipv4.chksum, ~m_old), m_new);
      end
      s2_v_d   = s2_v_q;
      s2_hdr_d = s2_hdr_q;
      if (s2_en) begin
         s2_v_d   = s1_v_q && !s1_drop_q;
         s2_hdr_d = mod_hdr;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: header registers are reset too because the output bits must read zero after reset.
         s1_v_q    <= 1'b0;
         s1_hdr_q  <= '0;
         s1_ipv4_q <= 1'b0;
         s1_drop_q <= 1'b0;
         s2_v_q    <= 1'b0;
         s2_hdr_q  <= '0;
      end else begin
         s1_v_q    <= s1_v_d;
         s1_hdr_q  <= s1_hdr_d;
         s1_ipv4_q <= s1_ipv4_d;
         s1_drop_q <= s1_drop_d;
         s2_v_q    <= s2_v_d;
         s2_hdr_q  <= s2_hdr_d;
      end
   end

   assign io.out_valid = s2_v_q;
   assign io.out_bits  = s2_hdr_q;

   npu_pc_node #(.MODULE_ID(MODULE_ID)) u_pc_node (
      .clk         (clk),
      .reset       (reset),
      .inc_in_i    (io.in_valid && s1_en),
      .inc_out_i   (s2_v_q && io.out_ready),
      .inc_drop_i  (s1_v_q && s1_drop_q && s2_en),
      .inc_stall_i (s2_v_q && !io.out_ready),
      .pc_valid_i  (io.pcIn_valid),
      .pc_msg_i    (io.pcIn_bits),
      .pc_valid_o  (io.pcOut_valid),
      .pc_msg_o    (io.pcOut_bits)
   );

endmodule

// File: tb/tb_npu_top.sv
// Directed bench for npu_top: vector table for header rewriting plus stall, PC-bus and reset sequences.
module tb_npu_top;
   import npu_pkg::*;

   typedef struct {
      logic [7:0]  l2;
      logic [7:0]  l3;
      logic [7:0]  ttl;
      logic [7:0]  proto;
      logic [15:0] chk;
      logic        exp_v;
      logic [7:0]  exp_ttl;
      logic [15:0] exp_chk;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   npu_if bus ();

   npu_top #(.MODULE_ID(16'h0001), .ETH_PROTO(8'd128), .IPV4_TYPE(8'd64)) dut (
      .clk   (clk),
      .reset (reset),
      .io    (bus)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_hdr(input string name, input hdr_t act, input hdr_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic hdr_t mk_hdr(input logic [7:0] l2, input logic [7:0] l3, input logic [7:0] ttl,
                                   input logic [7:0] proto, input logic [15:0] chk, input logic [15:0] id);
      hdr_t h;
      h.l2Protocol          = l2;
      h.eth_dstAddr         = 48'h0011_2233_4455;
      h.eth_srcAddr         = 48'h6677_8899_aabb;
      h.eth_l3Type          = l3;
      h.eth_length          = 16'd60;
      h.ipv4.version        = 4'd4;
      h.ipv4.hLength        = 4'd5;
      h.ipv4.tos            = 8'h10;
      h.ipv4.length         = 16'd46;
      h.ipv4.identification = id;
      h.ipv4.flagsOffset    = 16'h4000;
      h.ipv4.ttl            = ttl;
      h.ipv4.protocol       = proto;
      h.ipv4.chksum         = chk;
      h.ipv4.srcAddr        = 32'hC0A8_0001;
      h.ipv4.dstAddr        = 32'h0A00_0002;
      return h;
   endfunction

   task automatic pc_query(input string name, input logic [3:0] t, input logic [15:0] exp);
      pc_msg_t req;
      req = '{request: 1'b1, moduleId: 16'h0001, portId: 8'h5A, pcValue: 16'hDEAD, pcType: t};
      @(posedge clk); #1;
      bus.pcIn_valid = 1'b1;
      bus.pcIn_bits  = req;
      @(posedge clk); #1;
      bus.pcIn_valid = 1'b0;
      bus.pcIn_bits  = '0;
      @(negedge clk);
      check({name, "_valid"}, 64'(bus.pcOut_valid), 64'd1);
      check({name, "_msg"}, 64'(bus.pcOut_bits), 64'({1'b0, 16'h0001, 8'h5A, exp, t}));
   endtask

   task automatic pc_forward(input string name, input pc_msg_t m);
      @(posedge clk); #1;
      bus.pcIn_valid = 1'b1;
      bus.pcIn_bits  = m;
      @(posedge clk); #1;
      bus.pcIn_valid = 1'b0;
      bus.pcIn_bits  = '0;
      @(negedge clk);
      check({name, "_valid"}, 64'(bus.pcOut_valid), 64'd1);
      check({name, "_msg"}, 64'(bus.pcOut_bits), 64'(m));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vec_t     vecs [8];
      hdr_t     held;
      hdr_t     exp_h;
      hdr_t     zero_h;
      pc_msg_t  zero_pc;
      pc_msg_t  fwd;
      logic [15:0] rcv [$];
      int       idx;
      int       cyc;

      // Hand-computed: ttl-1 and checksum + 0x0100 with end-around carry; ttl<=1 IPv4 drops.
      vecs[0] = '{8'd128, 8'd64, 8'd3,   8'h06, 16'h1234, 1'b1, 8'd2,   16'h1334};
      vecs[1] = '{8'd128, 8'd64, 8'd2,   8'h11, 16'hFF80, 1'b1, 8'd1,   16'h0081};
      vecs[2] = '{8'd128, 8'd64, 8'd255, 8'h06, 16'hABCD, 1'b1, 8'd254, 16'hACCD};
      vecs[3] = '{8'd128, 8'd64, 8'd64,  8'h06, 16'hFFFF, 1'b1, 8'd63,  16'h0100};
      vecs[4] = '{8'd128, 8'd64, 8'd1,   8'h06, 16'h5555, 1'b0, 8'd0,   16'h0000};
      vecs[5] = '{8'd128, 8'd64, 8'd0,   8'h06, 16'h5555, 1'b0, 8'd0,   16'h0000};
      vecs[6] = '{8'd128, 8'd10, 8'd3,   8'h06, 16'h1234, 1'b1, 8'd3,   16'h1234};
      vecs[7] = '{8'd5,   8'd64, 8'd1,   8'h06, 16'h9999, 1'b1, 8'd1,   16'h9999};

      zero_h  = '0;
      zero_pc = '0;
      reset          = 1'b1;
      bus.in_valid   = 1'b0;
      bus.in_bits    = '0;
      bus.out_ready  = 1'b1;
      bus.pcIn_valid = 1'b0;
      bus.pcIn_bits  = '0;
      #2 reset = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_pc_valid", 64'(bus.pcOut_valid), 64'd0);
      check_hdr("rst_out_bits", bus.out_bits, zero_h);
      check("rst_pc_bits", 64'(bus.pcOut_bits), 64'(zero_pc));
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk);
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);

      // Vector table: one packet at a time, checking latency and rewritten header
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         bus.in_valid = 1'b1;
         bus.in_bits  = mk_hdr(vecs[i].l2, vecs[i].l3, vecs[i].ttl, vecs[i].proto, vecs[i].chk, 16'(i));
         @(negedge clk);
         check($sformatf("vec%0d_in_ready", i), 64'(bus.in_ready), 64'd1);
         @(posedge clk); #1;
         bus.in_valid = 1'b0;
         @(negedge clk);
         check($sformatf("vec%0d_lat1", i), 64'(bus.out_valid), 64'd0);
         @(posedge clk);
         @(negedge clk);
         check($sformatf("vec%0d_valid", i), 64'(bus.out_valid), 64'(vecs[i].exp_v));
         if (vecs[i].exp_v) begin
            exp_h = mk_hdr(vecs[i].l2, vecs[i].l3, vecs[i].exp_ttl, vecs[i].proto, vecs[i].exp_chk, 16'(i));
            check_hdr($sformatf("vec%0d_bits", i), bus.out_bits, exp_h);
         end
      end

      pc_query("pc_in",    PC_IN,    16'd8);
      pc_query("pc_out",   PC_OUT,   16'd6);
      pc_query("pc_drop",  PC_DROP,  16'd2);
      pc_query("pc_stall", PC_STALL, 16'd0);
      pc_query("pc_other", 4'd9,     16'd0);

      // Messages not addressed to this node pass through one cycle later, unchanged
      fwd = '{request: 1'b1, moduleId: 16'h0007, portId: 8'h03, pcValue: 16'hBEEF, pcType: 4'd2};
      pc_forward("fwd_other_id", fwd);
      fwd = '{request: 1'b0, moduleId: 16'h0001, portId: 8'h11, pcValue: 16'h1111, pcType: 4'd1};
      pc_forward("fwd_response", fwd);
      @(negedge clk);
      check("fwd_idle_valid", 64'(bus.pcOut_valid), 64'd0);

      // Back-to-back stream: one packet per cycle, first output two cycles after the first input
      for (int c = 0; c < 9; c++) begin
         @(posedge clk); #1;
         bus.in_valid = (c < 6);
         bus.in_bits  = mk_hdr(8'd128, 8'd64, 8'd3, 8'h06, 16'h1234, 16'h0200 + 16'(c));
         @(negedge clk);
         check($sformatf("stream%0d_in_ready", c), 64'(bus.in_ready), 64'd1);
         check($sformatf("stream%0d_valid", c), 64'(bus.out_valid), 64'(c >= 2 && c < 8));
         if (c >= 2 && c < 8) begin
            exp_h = mk_hdr(8'd128, 8'd64, 8'd2, 8'h06, 16'h1334, 16'h0200 + 16'(c - 2));
            check_hdr($sformatf("stream%0d_bits", c), bus.out_bits, exp_h);
         end
      end

      // Output stalled for five cycles while the source keeps offering packets
      idx = 0;
      cyc = 0;
      held = '0;
      while (rcv.size() < 10 && cyc < 200) begin
         @(posedge clk); #1;
         bus.out_ready = !(cyc >= 4 && cyc < 9);
         bus.in_valid  = (idx < 10);
         bus.in_bits   = mk_hdr(8'd128, 8'd64, 8'd10, 8'h06, 16'h2000, 16'h0100 + 16'(idx));
         @(negedge clk);
         if (cyc == 4) held = bus.out_bits;
         if (cyc >= 4 && cyc < 9) begin
            check($sformatf("stall%0d_in_ready", cyc), 64'(bus.in_ready), 64'd0);
            check($sformatf("stall%0d_valid", cyc), 64'(bus.out_valid), 64'd1);
            if (cyc > 4) check_hdr($sformatf("stall%0d_hold", cyc), bus.out_bits, held);
         end
         if (bus.out_valid && bus.out_ready) rcv.push_back(bus.out_bits.ipv4.identification);
         if (bus.in_valid && bus.in_ready) idx++;
         cyc++;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      check("stall_rcv_count", 64'(rcv.size()), 64'd10);
      for (int i = 0; i < 10; i++)
         if (i < rcv.size()) check($sformatf("stall_order%0d", i), 64'(rcv[i]), 64'(16'h0100 + 16'(i)));

      pc_query("pc_stall5", PC_STALL, 16'd5);
      pc_query("pc_in2",    PC_IN,    16'd24);
      pc_query("pc_out2",   PC_OUT,   16'd22);
      pc_query("pc_drop2",  PC_DROP,  16'd2);

      // Reset asserted mid-stream clears outputs at once and zeroes the counters
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         bus.in_valid = 1'b1;
         bus.in_bits  = mk_hdr(8'd128, 8'd64, 8'd9, 8'h06, 16'h4444, 16'h0300 + 16'(c));
      end
      @(negedge clk);
      check("mid_pre_valid", 64'(bus.out_valid), 64'd1);
      #1 reset = 1'b0;
      #1;
      check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
      check_hdr("mid_rst_bits", bus.out_bits, zero_h);
      bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
      check("post_rst_valid", 64'(bus.out_valid), 64'd0);
      pc_query("post_in",    PC_IN,    16'd0);
      pc_query("post_out",   PC_OUT,   16'd0);
      pc_query("post_drop",  PC_DROP,  16'd0);
      pc_query("post_stall", PC_STALL, 16'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
